// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcode values, FSM states and widths.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_MULU = 4'd10,
    ALU_DIVU = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus between the control unit (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic                         InValid;
  logic                         InReady;
  logic [alu_pkg::ALU_OP_W-1:0] ALUOp;
  logic [WIDTH-1:0]             ReadData1;
  logic [WIDTH-1:0]             ReadData2;
  logic                         OutValid;
  logic [WIDTH-1:0]             Result;
  logic [WIDTH-1:0]             ResultHi;
  logic                         Zero;
  logic                         Sign;

  modport master (
    output InValid, ALUOp, ReadData1, ReadData2,
    input  InReady, OutValid, Result, ResultHi, Zero, Sign
  );

  modport slave (
    input  InValid, ALUOp, ReadData1, ReadData2,
    output InReady, OutValid, Result, ResultHi, Zero, Sign
  );
endinterface

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add unsigned multiply and restoring unsigned
// divide, one result bit per cycle. The owner samples lo_next/hi_next in the
// cycle where last is high; that step's outputs are the final result.
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,    // load operands, begin WIDTH steps
  input  logic             is_div,   // 1: divide, 0: multiply
  input  logic [WIDTH-1:0] a,        // multiplier / dividend
  input  logic [WIDTH-1:0] b,        // multiplicand / divisor
  output logic             last,     // the step taken this cycle is the final one
  output logic [WIDTH-1:0] lo_next,  // product low / quotient after this step
  output logic [WIDTH-1:0] hi_next   // product high / remainder after this step
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;

  // One step of whichever algorithm is loaded.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (div_q) begin
      // Partial remainder stays below the divisor, so the W-bit difference is exact.
      hi_next = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
      lo_next = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    last = (cnt_q == CW'(1));
  end

  // Load on start, otherwise advance one step while the count is non-zero.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    if (start) begin
      hi_d   = '0;
      lo_d   = a;
      opnd_d = b;
      cnt_d  = CW'(WIDTH);
      div_d  = is_div;
    end else if (cnt_q != '0) begin
      hi_d  = hi_next;
      lo_d  = lo_next;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Control state is reset; the datapath is always reloaded by start before use.
  always_ff @(posedge clk) begin
    // NOTE: only the step counter needs a reset value; hi/lo/operand registers
    // are don't-care until start overwrites them, so leaving them unreset is safe.
    if (rst) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: valid/ready issue, single-cycle ops registered with
// latency 1, MULU/DIVU through the shared iterative datapath (latency WIDTH+1).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)  // derived, do not override
) (
  input logic      CLK,
  input logic      Reset,
  alu_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             out_valid_q, out_valid_d;

  alu_op_e          op;
  logic             accept;
  logic             iter_start;
  logic             iter_div;
  logic             iter_last;
  logic [WIDTH-1:0] iter_lo_next;
  logic [WIDTH-1:0] iter_hi_next;

  // Single-cycle operations; codes outside the defined set yield zero.
  function automatic logic [WIDTH-1:0] single_op(input alu_op_e f,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = a[SHW-1:0];
    case (f)
      ALU_ADD:  single_op = a + b;
      ALU_SUB:  single_op = a - b;
      ALU_AND:  single_op = a & b;
      ALU_OR:   single_op = a | b;
      ALU_XOR:  single_op = a ^ b;
      ALU_SLL:  single_op = b << sh;
      ALU_SRL:  single_op = b >> sh;
      ALU_SRA:  single_op = WIDTH'($signed(b) >>> sh);
      ALU_SLTU: single_op = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLT:  single_op = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  single_op = '0;
    endcase
  endfunction

  assign op     = alu_op_e'(bus.ALUOp);
  assign accept = bus.InValid && (state_q == ST_IDLE);

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (CLK),
    .rst     (Reset),
    .start   (iter_start),
    .is_div  (iter_div),
    .a       (bus.ReadData1),
    .b       (bus.ReadData2),
    .last    (iter_last),
    .lo_next (iter_lo_next),
    .hi_next (iter_hi_next)
  );

  // Next-state, result and handshake decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    out_valid_d = 1'b0;
    iter_start  = 1'b0;
    iter_div    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == ALU_MULU) begin
            iter_start = 1'b1;
            state_d    = ST_MUL;
          end else if (op == ALU_DIVU && bus.ReadData2 != '0) begin
            iter_start = 1'b1;
            iter_div   = 1'b1;
            state_d    = ST_DIV;
          end else if (op == ALU_DIVU) begin
            // Divide by zero: all-ones quotient, dividend as remainder.
            result_d    = '1;
            result_hi_d = bus.ReadData1;
            out_valid_d = 1'b1;
          end else begin
            result_d    = single_op(op, bus.ReadData1, bus.ReadData2);
            result_hi_d = '0;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_last) begin
          result_d    = iter_lo_next;
          result_hi_d = iter_hi_next;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (Reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.InReady  = (state_q == ST_IDLE);
  assign bus.OutValid = out_valid_q;
  assign bus.Result   = result_q;
  assign bus.ResultHi = result_hi_q;
  assign bus.Zero     = (result_q == '0);
  assign bus.Sign     = result_q[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a 32-bit instance checked every cycle against
// a behavioural model, plus a small 8-bit instance with directed checks.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut32 (.CLK(clk), .Reset(rst), .bus(bus32.slave));
  alu_seq #(.WIDTH(8))  dut8  (.CLK(clk), .Reset(rst), .bus(bus8.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural reference: plain arithmetic on the operands.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [31:0] h, output bit multi);
    logic [63:0] p;
    r = '0; h = '0; multi = 0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = b << a[4:0];
      4'd6:  r = b >> a[4:0];
      4'd7:  r = $signed(b) >>> a[4:0];
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: begin p = 64'(a) * 64'(b); r = p[31:0]; h = p[63:32]; multi = 1; end
      4'd11: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; h = a; end
        else begin r = a / b; h = a % b; multi = 1; end
      end
      default: ;
    endcase
  endfunction

  // Model state, advanced at each rising edge from the bench-driven inputs.
  bit          cmp_en = 0;
  bit          m_acc = 0;
  bit          m_ready = 1;
  bit          m_ov = 0;
  int          m_busy = 0;
  logic [31:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0;

  always @(posedge clk) begin
    logic [31:0] r, h;
    bit multi;
    m_acc = 0;
    if (rst) begin
      m_ready = 1; m_ov = 0; m_res = '0; m_hi = '0; m_busy = 0; cmp_en = 1;
    end else begin
      m_ov = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ov = 1; m_res = p_res; m_hi = p_hi; m_ready = 1;
        end
      end else if (bus32.InValid) begin
        m_acc = 1;
        model_op(bus32.ALUOp, bus32.ReadData1, bus32.ReadData2, r, h, multi);
        if (multi) begin
          p_res = r; p_hi = h; m_busy = 32; m_ready = 0;
        end else begin
          m_res = r; m_hi = h; m_ov = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the 32-bit instance against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",  bus32.InReady,  m_ready);
      check("out_valid", bus32.OutValid, m_ov);
      check("result",    bus32.Result,   m_res);
      check("result_hi", bus32.ResultHi, m_hi);
      check("zero",      bus32.Zero,     m_res == 32'd0);
      check("sign",      bus32.Sign,     m_res[31]);
    end
  end

  // Present a request until the model says it was accepted; then scramble inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    bit got = 0;
    bus32.ALUOp = op; bus32.ReadData1 = a; bus32.ReadData2 = b; bus32.InValid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      got = m_acc;
    end
    if (!got) check("accept_timeout", 0, 1);
    if (!hold) begin
      bus32.InValid   = 1'b0;
      bus32.ALUOp     = 4'($urandom);
      bus32.ReadData1 = $urandom;
      bus32.ReadData2 = $urandom;
    end
  endtask

  // Count cycles from acceptance (cycle 1) until OutValid, bounded.
  task automatic wait_ov(output int n, output int busy_acc);
    n = 1; busy_acc = 0;
    while (!bus32.OutValid && n < 40) begin
      if (bus32.InValid && bus32.InReady) busy_acc++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n, busy_acc, ovs;
    logic [3:0]  op;
    logic [31:0] a, b;

    bus32.InValid = 1'b0; bus32.ALUOp = '0; bus32.ReadData1 = '0; bus32.ReadData2 = '0;
    bus8.InValid  = 1'b0; bus8.ALUOp  = '0; bus8.ReadData1  = '0; bus8.ReadData2  = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_result", bus32.Result, 0);
    check("rst_zero", bus32.Zero, 1);
    check("rst_ready", bus32.InReady, 1);
    check("rst_ov", bus32.OutValid, 0);

    issue(4'd1, 32'd5, 32'd7, 0);
    check("sub_ov", bus32.OutValid, 1);
    check("sub_res", bus32.Result, 32'hFFFF_FFFE);
    check("sub_sign", bus32.Sign, 1);
    check("sub_zero", bus32.Zero, 0);
    issue(4'd0, 32'd1, 32'd1, 0);
    check("add_b2b", bus32.Result, 32'd2);
    check("add_b2b_ov", bus32.OutValid, 1);

    issue(4'd7, 32'd4, 32'h8000_0000, 0);
    check("sra", bus32.Result, 32'hF800_0000);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    check("slt", bus32.Result, 32'd1);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    check("sltu", bus32.Result, 32'd0);

    issue(4'd10, 32'hFFFF_FFFF, 32'd2, 1);
    wait_ov(n, busy_acc);
    bus32.InValid = 1'b0;
    check("mul_latency", n, 33);
    check("mul_busy_accepts", busy_acc, 0);
    check("mul_lo", bus32.Result, 32'hFFFF_FFFE);
    check("mul_hi", bus32.ResultHi, 32'd1);

    issue(4'd11, 32'd100, 32'd7, 0);
    wait_ov(n, busy_acc);
    check("div_latency", n, 33);
    check("div_q", bus32.Result, 32'd14);
    check("div_r", bus32.ResultHi, 32'd2);
    issue(4'd11, 32'd9, 32'd0, 0);
    check("div0_ov", bus32.OutValid, 1);
    check("div0_q", bus32.Result, 32'hFFFF_FFFF);
    check("div0_r", bus32.ResultHi, 32'd9);

    issue(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mrst_ready", bus32.InReady, 1);
    check("mrst_ov", bus32.OutValid, 0);
    check("mrst_result", bus32.Result, 0);
    check("mrst_zero", bus32.Zero, 1);
    ovs = 0;
    repeat (40) begin @(posedge clk); #1; if (bus32.OutValid) ovs++; end
    check("mrst_no_late_ov", ovs, 0);
    issue(4'd0, 32'd3, 32'd4, 0);
    check("mrst_add", bus32.Result, 32'd7);

    for (int k = 0; k < 300; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
      if (op == 4'd11) begin
        if ($urandom_range(0, 3) == 0) b = 0;
        else if ($urandom_range(0, 1) == 0) b = $urandom_range(1, 50);
      end
      issue(op, a, b, 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    bus8.ALUOp = 4'd10; bus8.ReadData1 = 8'hFF; bus8.ReadData2 = 8'hFF; bus8.InValid = 1'b1;
    @(posedge clk); #1 bus8.InValid = 1'b0;
    n = 1;
    while (!bus8.OutValid && n < 20) begin @(posedge clk); #1; n++; end
    check("w8_mul_latency", n, 9);
    check("w8_mul_lo", bus8.Result, 8'h01);
    check("w8_mul_hi", bus8.ResultHi, 8'hFE);
    bus8.ALUOp = 4'd5; bus8.ReadData1 = 8'd9; bus8.ReadData2 = 8'h03; bus8.InValid = 1'b1;
    @(posedge clk); #1 bus8.InValid = 1'b0;
    check("w8_sll_ov", bus8.OutValid, 1);
    check("w8_sll", bus8.Result, 8'h06);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
